// File: rtl/audio_mem_arbiter.sv
// Audio memory arbiter: shares one single-port word RAM between a CPU,
// a sector-DMA writer and the audio decoder's read port. Fixed priority
// CPU > DMA > decoder, with a starvation override that forces the decoder
// to win after DEC_STARVE_LIMIT consecutive lost arbitrations.
// Each access takes IDLE/RESP -> ACCESS -> RESP, so back-to-back traffic
// runs at one RAM access every two cycles.
module audio_mem_arbiter #(
  parameter int DEC_STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  // decoder read port
  input  logic [12:0] dec_addr,
  input  logic        dec_rd,
  output logic [15:0] dec_data,
  output logic        dec_ack,
  output logic        dec_ack_q,
  // sector-DMA write port
  input  logic [12:0] dma_addr,
  input  logic        dma_wr,
  input  logic [15:0] dma_wdata,
  output logic        dma_ack,
  // CPU port
  input  logic [12:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  // RAM port
  output logic        ram_en,
  output logic        ram_we,
  output logic [12:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata
);

  localparam int CNT_W = (DEC_STARVE_LIMIT < 1) ? 1 : $clog2(DEC_STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(DEC_STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_CPU  = 2'd1,
    SRC_DMA  = 2'd2,
    SRC_DEC  = 2'd3
  } src_t;

  state_t           state, state_nxt;
  src_t             grant;
  src_t             win_src;
  logic             win_we;
  logic [12:0]      win_addr;
  logic [15:0]      win_wdata;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
  logic [15:0]      dec_data_q;
  logic [15:0]      cpu_rdata_q;
  logic             dec_ack_r;

  logic cpu_req, dma_req, dec_req;
  logic arb_en;
  logic starved;
  logic in_access, in_resp;
  logic cpu_cap;

  // Pending requests; the requester being acknowledged this cycle is
  // masked so its still-high request does not win a second time.
  always_comb begin
    cpu_req = (cpu_rd | cpu_wr) & ~((state == RESP) & (win_src == SRC_CPU));
    dma_req = dma_wr & ~((state == RESP) & (win_src == SRC_DMA));
    dec_req = dec_rd & ~((state == RESP) & (win_src == SRC_DEC));
  end

  assign arb_en  = ((state == IDLE) || (state == RESP)) && (cpu_req || dma_req || dec_req);
  assign starved = (starve_cnt == STARVE_MAX);

  // Winner selection: fixed priority unless the decoder has been starved.
  // NOTE: every signal assigned in an always_comb gets a default first,
  // otherwise a missed branch would infer a latch.
  always_comb begin
    grant = SRC_NONE;
    if (dec_req && starved)  grant = SRC_DEC;
    else if (cpu_req)        grant = SRC_CPU;
    else if (dma_req)        grant = SRC_DMA;
    else if (dec_req)        grant = SRC_DEC;
  end

  // Starvation counter: counts arbitrations the decoder loses while waiting.
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!dec_rd) begin
      starve_cnt_nxt = '0;
    end else if (arb_en) begin
      if (grant == SRC_DEC)
        starve_cnt_nxt = '0;
      else if (dec_req && (starve_cnt != STARVE_MAX))
        starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = arb_en ? ACCESS : IDLE;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = arb_en ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, winner capture, starvation counter and read-data holds.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      win_src     <= SRC_NONE;
      win_we      <= 1'b0;
      win_addr    <= '0;
      win_wdata   <= '0;
      starve_cnt  <= '0;
      dec_data_q  <= '0;
      cpu_rdata_q <= '0;
      dec_ack_r   <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      dec_ack_r  <= dec_ack;
      if (arb_en) begin
        win_src <= grant;
        unique case (grant)
          SRC_CPU: begin
            // A simultaneous read+write from the CPU is treated as a write.
            win_we    <= cpu_wr;
            win_addr  <= cpu_addr;
            win_wdata <= cpu_wdata;
          end
          SRC_DMA: begin
            win_we    <= 1'b1;
            win_addr  <= dma_addr;
            win_wdata <= dma_wdata;
          end
          SRC_DEC: begin
            win_we    <= 1'b0;
            win_addr  <= dec_addr;
            win_wdata <= '0;
          end
          default: begin
            win_we    <= 1'b0;
            win_addr  <= '0;
            win_wdata <= '0;
          end
        endcase
      end
      if (dec_ack) dec_data_q  <= ram_rdata;
      if (cpu_cap) cpu_rdata_q <= ram_rdata;
    end
  end

  // Outputs are qualified with reset_n so that an access caught by reset
  // never strobes the RAM or acknowledges, even in the cycle reset arrives.
  assign in_access = reset_n && (state == ACCESS);
  assign in_resp   = reset_n && (state == RESP);

  // RAM strobe and registered-winner fields.
  always_comb begin
    ram_en    = in_access;
    ram_we    = in_access & win_we;
    ram_addr  = in_access ? win_addr  : '0;
    ram_wdata = in_access ? win_wdata : '0;
  end

  // Acks and read data; read data passes straight through in the ack cycle
  // and is held afterwards.
  always_comb begin
    cpu_ack   = in_resp && (win_src == SRC_CPU);
    dma_ack   = in_resp && (win_src == SRC_DMA);
    dec_ack   = in_resp && (win_src == SRC_DEC);
    cpu_cap   = cpu_ack && !win_we;
    dec_ack_q = reset_n & dec_ack_r;
    dec_data  = !reset_n ? '0 : (dec_ack ? ram_rdata : dec_data_q);
    cpu_rdata = !reset_n ? '0 : (cpu_cap ? ram_rdata : cpu_rdata_q);
  end

endmodule

// File: tb/tb_audio_mem_arbiter.sv
// Self-checking bench for audio_mem_arbiter: a per-cycle vector table for
// the single-access, priority, reset and abort cases, plus a hand-written
// starvation sequence and a cycle monitor for the global invariants.
module tb_audio_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [12:0] dec_addr;
  logic        dec_rd;
  logic [15:0] dec_data;
  logic        dec_ack, dec_ack_q;
  logic [12:0] dma_addr;
  logic        dma_wr;
  logic [15:0] dma_wdata;
  logic        dma_ack;
  logic [12:0] cpu_addr;
  logic        cpu_rd, cpu_wr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic        ram_en, ram_we;
  logic [12:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  audio_mem_arbiter #(.DEC_STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .dec_addr(dec_addr), .dec_rd(dec_rd), .dec_data(dec_data),
    .dec_ack(dec_ack), .dec_ack_q(dec_ack_q),
    .dma_addr(dma_addr), .dma_wr(dma_wr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous, read data valid the cycle after ram_en.
  // Read data is scribbled during writes so a wrong capture shows up.
  logic [15:0] mem [0:8191];
  always @(posedge clk) begin
    if (!reset_n) begin
      mem[13'h1400] <= 16'hBEEF;
      mem[13'h1FFF] <= 16'h7E57;
      ram_rdata     <= 16'h0000;
    end else if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        ram_rdata     <= 16'hDEAD;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Invariants checked every cycle: one ack at most, no back-to-back
  // ram_en, dec_ack_q is dec_ack delayed by one cycle.
  logic prev_en = 1'b0;
  logic prev_dec_ack = 1'b0;
  always @(negedge clk) begin
    check("one_ack", 32'($onehot0({cpu_ack, dma_ack, dec_ack})), 32'd1);
    check("ram_en_gap", 32'(prev_en & ram_en), 32'd0);
    check("dec_ack_q", 32'(dec_ack_q), reset_n ? 32'(prev_dec_ack) : 32'd0);
    prev_en      = ram_en;
    prev_dec_ack = dec_ack;
  end

  // req = {cpu_rd, cpu_wr, dma_wr, dec_rd}; acks = {cpu, dma, dec, dec_q}
  typedef struct {
    string       nm;
    logic        rst;
    logic [3:0]  req;
    logic [12:0] dec_a;
    logic [12:0] dma_a;
    logic [15:0] dma_d;
    logic [12:0] cpu_a;
    logic [15:0] cpu_d;
    logic        e_en;
    logic        e_we;
    logic [12:0] e_addr;
    logic [15:0] e_wd;
    logic [3:0]  e_acks;
    logic [15:0] e_dd;
    logic [15:0] e_cr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input string nm, input logic rst, input logic [3:0] req,
                             input logic [12:0] dec_a, input logic [12:0] dma_a,
                             input logic [15:0] dma_d, input logic [12:0] cpu_a,
                             input logic [15:0] cpu_d, input logic e_en, input logic e_we,
                             input logic [12:0] e_addr, input logic [15:0] e_wd,
                             input logic [3:0] e_acks, input logic [15:0] e_dd,
                             input logic [15:0] e_cr);
    vec_t r;
    r.nm = nm; r.rst = rst; r.req = req;
    r.dec_a = dec_a; r.dma_a = dma_a; r.dma_d = dma_d; r.cpu_a = cpu_a; r.cpu_d = cpu_d;
    r.e_en = e_en; r.e_we = e_we; r.e_addr = e_addr; r.e_wd = e_wd;
    r.e_acks = e_acks; r.e_dd = e_dd; r.e_cr = e_cr;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          grants;
    bit          done;
    logic [12:0] exp_order [5];

    //            name            rst req      dec_a     dma_a     dma_d      cpu_a     cpu_d      en  we  addr      wdata      acks     dec_data   cpu_rdata
    vecs.push_back(v("rst0",       0, 4'b0000, 13'h0,    13'h0,    16'h0,     13'h0,    16'h0,     0,  0,  13'h0,    16'h0,     4'b0000, 16'h0,     16'h0));
    vecs.push_back(v("rst1",       0, 4'b0000, 13'h0,    13'h0,    16'h0,     13'h0,    16'h0,     0,  0,  13'h0,    16'h0,     4'b0000, 16'h0,     16'h0));
    vecs.push_back(v("idle",       1, 4'b0000, 13'h0,    13'h0,    16'h0,     13'h0,    16'h0,     0,  0,  13'h0,    16'h0,     4'b0000, 16'h0,     16'h0));
    vecs.push_back(v("dec_req",    1, 4'b0001, 13'h1400, 13'h0,    16'h0,     13'h0,    16'h0,     0,  0,  13'h0,    16'h0,     4'b0000, 16'h0,     16'h0));
    vecs.push_back(v("dec_access", 1, 4'b0001, 13'h1400, 13'h0,    16'h0,     13'h0,    16'h0,     1,  0,  13'h1400, 16'h0,     4'b0000, 16'h0,     16'h0));
    vecs.push_back(v("dec_resp",   1, 4'b0001, 13'h1400, 13'h0,    16'h0,     13'h0,    16'h0,     0,  0,  13'h0,    16'h0,     4'b0010, 16'hBEEF,  16'h0));
    vecs.push_back(v("dec_ackq",   1, 4'b0000, 13'h0,    13'h0,    16'h0,     13'h0,    16'h0,     0,  0,  13'h0,    16'h0,     4'b0001, 16'hBEEF,  16'h0));
    vecs.push_back(v("dec_hold",   1, 4'b0000, 13'h0,    13'h0,    16'h0,     13'h0,    16'h0,     0,  0,  13'h0,    16'h0,     4'b0000, 16'hBEEF,  16'h0));
    vecs.push_back(v("dma_req",    1, 4'b0010, 13'h0,    13'h0123, 16'hA5A5,  13'h0,    16'h0,     0,  0,  13'h0,    16'h0,     4'b0000, 16'hBEEF,  16'h0));
    vecs.push_back(v("dma_access", 1, 4'b0010, 13'h0,    13'h0123, 16'hA5A5,  13'h0,    16'h0,     1,  1,  13'h0123, 16'hA5A5,  4'b0000, 16'hBEEF,  16'h0));
    vecs.push_back(v("dma_resp",   1, 4'b0010, 13'h0,    13'h0123, 16'hA5A5,  13'h0,    16'h0,     0,  0,  13'h0,    16'h0,     4'b0100, 16'hBEEF,  16'h0));
    vecs.push_back(v("dma_done",   1, 4'b0000, 13'h0,    13'h0,    16'h0,     13'h0,    16'h0,     0,  0,  13'h0,    16'h0,     4'b0000, 16'hBEEF,  16'h0));
    vecs.push_back(v("cpurd_req",  1, 4'b1000, 13'h0,    13'h0,    16'h0,     13'h0123, 16'h0,     0,  0,  13'h0,    16'h0,     4'b0000, 16'hBEEF,  16'h0));
    vecs.push_back(v("cpurd_acc",  1, 4'b1000, 13'h0,    13'h0,    16'h0,     13'h0123, 16'h0,     1,  0,  13'h0123, 16'h0,     4'b0000, 16'hBEEF,  16'h0));
    vecs.push_back(v("cpurd_resp", 1, 4'b1000, 13'h0,    13'h0,    16'h0,     13'h0123, 16'h0,     0,  0,  13'h0,    16'h0,     4'b1000, 16'hBEEF,  16'hA5A5));
    vecs.push_back(v("cpurd_done", 1, 4'b0000, 13'h0,    13'h0,    16'h0,     13'h0,    16'h0,     0,  0,  13'h0,    16'h0,     4'b0000, 16'hBEEF,  16'hA5A5));
    vecs.push_back(v("conf_req",   1, 4'b1100, 13'h0,    13'h0,    16'h0,     13'h0A00, 16'h1234,  0,  0,  13'h0,    16'h0,     4'b0000, 16'hBEEF,  16'hA5A5));
    vecs.push_back(v("conf_acc",   1, 4'b1100, 13'h0,    13'h0,    16'h0,     13'h0A00, 16'h1234,  1,  1,  13'h0A00, 16'h1234,  4'b0000, 16'hBEEF,  16'hA5A5));
    vecs.push_back(v("conf_resp",  1, 4'b1100, 13'h0,    13'h0,    16'h0,     13'h0A00, 16'h1234,  0,  0,  13'h0,    16'h0,     4'b1000, 16'hBEEF,  16'hA5A5));
    vecs.push_back(v("conf_done",  1, 4'b0000, 13'h0,    13'h0,    16'h0,     13'h0,    16'h0,     0,  0,  13'h0,    16'h0,     4'b0000, 16'hBEEF,  16'hA5A5));
    vecs.push_back(v("sim_req",    1, 4'b0111, 13'h1FFF, 13'h0020, 16'h2222,  13'h0010, 16'h1111,  0,  0,  13'h0,    16'h0,     4'b0000, 16'hBEEF,  16'hA5A5));
    vecs.push_back(v("sim_cpu_acc",1, 4'b0111, 13'h1FFF, 13'h0020, 16'h2222,  13'h0010, 16'h1111,  1,  1,  13'h0010, 16'h1111,  4'b0000, 16'hBEEF,  16'hA5A5));
    vecs.push_back(v("sim_cpu_ack",1, 4'b0111, 13'h1FFF, 13'h0020, 16'h2222,  13'h0010, 16'h1111,  0,  0,  13'h0,    16'h0,     4'b1000, 16'hBEEF,  16'hA5A5));
    vecs.push_back(v("sim_dma_acc",1, 4'b0011, 13'h1FFF, 13'h0020, 16'h2222,  13'h0,    16'h0,     1,  1,  13'h0020, 16'h2222,  4'b0000, 16'hBEEF,  16'hA5A5));
    vecs.push_back(v("sim_dma_ack",1, 4'b0011, 13'h1FFF, 13'h0020, 16'h2222,  13'h0,    16'h0,     0,  0,  13'h0,    16'h0,     4'b0100, 16'hBEEF,  16'hA5A5));
    vecs.push_back(v("sim_dec_acc",1, 4'b0001, 13'h1FFF, 13'h0,    16'h0,     13'h0,    16'h0,     1,  0,  13'h1FFF, 16'h0,     4'b0000, 16'hBEEF,  16'hA5A5));
    vecs.push_back(v("sim_dec_ack",1, 4'b0001, 13'h1FFF, 13'h0,    16'h0,     13'h0,    16'h0,     0,  0,  13'h0,    16'h0,     4'b0010, 16'h7E57,  16'hA5A5));
    vecs.push_back(v("sim_done",   1, 4'b0000, 13'h0,    13'h0,    16'h0,     13'h0,    16'h0,     0,  0,  13'h0,    16'h0,     4'b0001, 16'h7E57,  16'hA5A5));
    vecs.push_back(v("rst_req",    1, 4'b0010, 13'h0,    13'h0055, 16'h5555,  13'h0,    16'h0,     0,  0,  13'h0,    16'h0,     4'b0000, 16'h7E57,  16'hA5A5));
    vecs.push_back(v("rst_in_acc", 0, 4'b0010, 13'h0,    13'h0055, 16'h5555,  13'h0,    16'h0,     0,  0,  13'h0,    16'h0,     4'b0000, 16'h0,     16'h0));
    vecs.push_back(v("rst_rearb",  1, 4'b0010, 13'h0,    13'h0055, 16'h5555,  13'h0,    16'h0,     0,  0,  13'h0,    16'h0,     4'b0000, 16'h0,     16'h0));
    vecs.push_back(v("rst_access", 1, 4'b0010, 13'h0,    13'h0055, 16'h5555,  13'h0,    16'h0,     1,  1,  13'h0055, 16'h5555,  4'b0000, 16'h0,     16'h0));
    vecs.push_back(v("rst_ack",    1, 4'b0010, 13'h0,    13'h0055, 16'h5555,  13'h0,    16'h0,     0,  0,  13'h0,    16'h0,     4'b0100, 16'h0,     16'h0));
    vecs.push_back(v("rst_done",   1, 4'b0000, 13'h0,    13'h0,    16'h0,     13'h0,    16'h0,     0,  0,  13'h0,    16'h0,     4'b0000, 16'h0,     16'h0));
    vecs.push_back(v("abort_req",  1, 4'b0101, 13'h1400, 13'h0,    16'h0,     13'h0030, 16'h3030,  0,  0,  13'h0,    16'h0,     4'b0000, 16'h0,     16'h0));
    vecs.push_back(v("abort_acc",  1, 4'b0100, 13'h0,    13'h0,    16'h0,     13'h0030, 16'h3030,  1,  1,  13'h0030, 16'h3030,  4'b0000, 16'h0,     16'h0));
    vecs.push_back(v("abort_ack",  1, 4'b0100, 13'h0,    13'h0,    16'h0,     13'h0030, 16'h3030,  0,  0,  13'h0,    16'h0,     4'b1000, 16'h0,     16'h0));
    vecs.push_back(v("abort_idle", 1, 4'b0000, 13'h0,    13'h0,    16'h0,     13'h0,    16'h0,     0,  0,  13'h0,    16'h0,     4'b0000, 16'h0,     16'h0));
    vecs.push_back(v("abort_none", 1, 4'b0000, 13'h0,    13'h0,    16'h0,     13'h0,    16'h0,     0,  0,  13'h0,    16'h0,     4'b0000, 16'h0,     16'h0));
    vecs.push_back(v("late_req",   1, 4'b1000, 13'h0,    13'h0,    16'h0,     13'h1400, 16'h0,     0,  0,  13'h0,    16'h0,     4'b0000, 16'h0,     16'h0));
    vecs.push_back(v("late_acc",   1, 4'b0000, 13'h0,    13'h0,    16'h0,     13'h0,    16'h0,     1,  0,  13'h1400, 16'h0,     4'b0000, 16'h0,     16'h0));
    vecs.push_back(v("late_ack",   1, 4'b0000, 13'h0,    13'h0,    16'h0,     13'h0,    16'h0,     0,  0,  13'h0,    16'h0,     4'b1000, 16'h0,     16'hBEEF));
    vecs.push_back(v("late_hold",  1, 4'b0000, 13'h0,    13'h0,    16'h0,     13'h0,    16'h0,     0,  0,  13'h0,    16'h0,     4'b0000, 16'h0,     16'hBEEF));

    reset_n = 1'b0;
    {cpu_rd, cpu_wr, dma_wr, dec_rd} = 4'b0000;
    dec_addr = '0; dma_addr = '0; dma_wdata = '0; cpu_addr = '0; cpu_wdata = '0;
    @(posedge clk); #1;

    // Table: inputs applied after the edge, outputs compared mid-cycle.
    foreach (vecs[i]) begin
      reset_n = vecs[i].rst;
      {cpu_rd, cpu_wr, dma_wr, dec_rd} = vecs[i].req;
      dec_addr  = vecs[i].dec_a;
      dma_addr  = vecs[i].dma_a;
      dma_wdata = vecs[i].dma_d;
      cpu_addr  = vecs[i].cpu_a;
      cpu_wdata = vecs[i].cpu_d;
      @(negedge clk);
      check({vecs[i].nm, ".ram_en"}, 32'(ram_en), 32'(vecs[i].e_en));
      if (vecs[i].e_en) begin
        check({vecs[i].nm, ".ram_we"},   32'(ram_we),   32'(vecs[i].e_we));
        check({vecs[i].nm, ".ram_addr"}, 32'(ram_addr), 32'(vecs[i].e_addr));
        if (vecs[i].e_we)
          check({vecs[i].nm, ".ram_wdata"}, 32'(ram_wdata), 32'(vecs[i].e_wd));
      end
      if (!vecs[i].rst) begin
        check({vecs[i].nm, ".ram_fields"}, {ram_we, ram_addr, ram_wdata}, 32'd0);
      end
      check({vecs[i].nm, ".acks"}, 32'({cpu_ack, dma_ack, dec_ack, dec_ack_q}), 32'(vecs[i].e_acks));
      check({vecs[i].nm, ".dec_data"},  32'(dec_data),  32'(vecs[i].e_dd));
      check({vecs[i].nm, ".cpu_rdata"}, 32'(cpu_rdata), 32'(vecs[i].e_cr));
      @(posedge clk); #1;
    end

    // RAM contents written by the table
    check("mem_0123", 32'(mem[13'h0123]), 32'h0000A5A5);
    check("mem_0A00", 32'(mem[13'h0A00]), 32'h00001234);
    check("mem_0010", 32'(mem[13'h0010]), 32'h00001111);
    check("mem_0020", 32'(mem[13'h0020]), 32'h00002222);
    check("mem_0055", 32'(mem[13'h0055]), 32'h00005555);
    check("mem_0030", 32'(mem[13'h0030]), 32'h00003030);

    // Starvation: CPU and DMA held alongside the decoder; grants must go
    // cpu, dma, cpu, dma, then the decoder on the 5th arbitration.
    exp_order[0] = 13'h0100; exp_order[1] = 13'h0200; exp_order[2] = 13'h0100;
    exp_order[3] = 13'h0200; exp_order[4] = 13'h1400;
    cpu_addr = 13'h0100; cpu_wdata = 16'hC0C0; cpu_wr = 1'b1;
    dma_addr = 13'h0200; dma_wdata = 16'hD0D0; dma_wr = 1'b1;
    dec_addr = 13'h1400; dec_rd = 1'b1;
    grants = 0;
    done   = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (ram_en) begin
        if (grants < 5) check($sformatf("starve_grant%0d", grants), 32'(ram_addr), 32'(exp_order[grants]));
        grants++;
      end
      if (dec_ack) begin
        check("starve_grants", 32'(grants), 32'd5);
        check("starve_dec_data", 32'(dec_data), 32'h0000BEEF);
        check("starve_cnt_clear", 32'(dut.starve_cnt), 32'd0);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("starve_timeout", 32'd0, 32'd1);
    {cpu_rd, cpu_wr, dma_wr, dec_rd} = 4'b0000;
    repeat (6) @(posedge clk);
    #1;
    check("mem_0100", 32'(mem[13'h0100]), 32'h0000C0C0);
    check("mem_0200", 32'(mem[13'h0200]), 32'h0000D0D0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
